// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: core command codes and FSM states.
// The command codes are also used by the core control unit.
package dmem_responder_pkg;

    localparam logic [3:0] MEM_IDLE  = 4'd0;
    localparam logic [3:0] MEM_READ  = 4'd1;
    localparam logic [3:0] MEM_WRITE = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RWAIT,
        ST_ACK
    } state_e;

    // Codes other than READ/WRITE are treated as idle and are never granted.
    function automatic logic isRequest(input logic [3:0] ctrl);
        return (ctrl == MEM_READ) || (ctrl == MEM_WRITE);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Bundle between the core array / data RAM and the responder.
// The slave side is the responder; the master side is the cores plus the RAM.
interface dmem_responder_if #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    import dmem_responder_pkg::*;

    logic [4*NCORES-1:0]  mem_ctrl;
    logic [AW*NCORES-1:0] daddr;
    logic [DW*NCORES-1:0] dwdata;
    logic [DW*NCORES-1:0] ddin;
    logic [NCORES-1:0]    dacq;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic                 ram_we;
    logic [DW-1:0]        ram_rdata;

    modport slave (
        input  mem_ctrl, daddr, dwdata, ram_rdata,
        output ddin, dacq, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output mem_ctrl, daddr, dwdata, ram_rdata,
        input  ddin, dacq, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/dmem_responder_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first unmasked requester
// searching upward from the pointer, wrapping at NCORES.
module rr_arbiter #(
    parameter int NCORES = 4,
    parameter int PW     = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    input  logic [NCORES-1:0] mask_i,
    output logic [NCORES-1:0] grant_o,
    output logic [PW-1:0]     grant_idx_o,
    output logic              any_grant_o
);

    logic [NCORES-1:0] eligible;

    assign eligible = req_i & ~mask_i;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            int idx;
            idx = (int'(ptr_i) + k) % NCORES;
            if (!any_grant_o && eligible[idx]) begin
                any_grant_o      = 1'b1;
                grant_o[idx]     = 1'b1;
                grant_idx_o      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder for the multicore data-memory handshake: round-robin arbitration of
// core requests onto one synchronous single-port RAM, one transaction in flight.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    dmem_responder_if.slave  bus
);

    localparam int PW = $clog2(NCORES);

    state_e            state_q;
    logic [PW-1:0]     grant_q;
    logic [PW-1:0]     ptr_q;
    logic [NCORES-1:0] grant_oh_q;
    logic [NCORES-1:0] mask_q;
    logic [NCORES-1:0] dacq_q;
    logic              write_q;
    logic [AW-1:0]     ram_addr_q;
    logic [DW-1:0]     ram_wdata_q;
    logic              ram_we_q;
    logic [DW-1:0]     ddin_q [NCORES];

    logic [NCORES-1:0] req;
    logic [NCORES-1:0] gnt_d;
    logic [PW-1:0]     gnt_idx_d;
    logic              any_gnt_d;
    logic [3:0]        gnt_ctrl;
    logic [AW-1:0]     gnt_addr;
    logic [DW-1:0]     gnt_wdata;

    for (genvar g = 0; g < NCORES; g++) begin : g_core
        assign req[g]                 = isRequest(bus.mem_ctrl[4*g +: 4]);
        assign bus.ddin[DW*g +: DW]   = ddin_q[g];
    end

    rr_arbiter #(
        .NCORES (NCORES),
        .PW     (PW)
    ) u_arb (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .mask_i      (mask_q),
        .grant_o     (gnt_d),
        .grant_idx_o (gnt_idx_d),
        .any_grant_o (any_gnt_d)
    );

    assign gnt_ctrl  = bus.mem_ctrl[4*gnt_idx_d +: 4];
    assign gnt_addr  = bus.daddr[AW*gnt_idx_d +: AW];
    assign gnt_wdata = bus.dwdata[DW*gnt_idx_d +: DW];

    // The mask lives for exactly the first IDLE cycle after ACK so a request the
    // core is still holding cannot be served twice.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            grant_oh_q  <= '0;
            mask_q      <= '0;
            dacq_q      <= '0;
            write_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            for (int i = 0; i < NCORES; i++) begin
                ddin_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mask_q <= '0;
                    if (any_gnt_d) begin
                        grant_q     <= gnt_idx_d;
                        grant_oh_q  <= gnt_d;
                        write_q     <= (gnt_ctrl == MEM_WRITE);
                        ram_addr_q  <= gnt_addr;
                        ram_wdata_q <= gnt_wdata;
                        ram_we_q    <= (gnt_ctrl == MEM_WRITE);
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ram_we_q <= 1'b0;
                    if (write_q) begin
                        dacq_q  <= grant_oh_q;
                        state_q <= ST_ACK;
                    end else begin
                        state_q <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    ddin_q[grant_q] <= bus.ram_rdata;
                    dacq_q          <= grant_oh_q;
                    state_q         <= ST_ACK;
                end
                ST_ACK: begin
                    dacq_q  <= '0;
                    mask_q  <= grant_oh_q;
                    ptr_q   <= (grant_q == PW'(NCORES - 1)) ? '0 : grant_q + PW'(1);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dacq      = dacq_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus randomized multi-core
// traffic, checked against a flat reference memory and per-core expected queues.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int NCORES    = 4;
    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int LAT_BOUND = 4*NCORES + 4;

    typedef struct {
        logic          isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            issueCycle;
    } txn_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.NCORES(NCORES), .AW(AW), .DW(DW)) bus ();

    dmem_responder #(.NCORES(NCORES), .AW(AW), .DW(DW)) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    logic [3:0]    coreCtrl [NCORES];
    logic [AW-1:0] coreAddr [NCORES];
    logic [DW-1:0] coreData [NCORES];

    txn_t          expQ [NCORES][$];
    logic [DW-1:0] refMem [256];
    logic [DW-1:0] expDdin [NCORES];
    logic [DW-1:0] ramMem [256];
    int            ackLog [$];
    int            ackCount [NCORES];
    int            lastAckCycle [NCORES];
    int            issueCycle [NCORES];
    int            ackTotal = 0;
    int            weCount = 0;
    int            weTotal = 0;
    logic [AW-1:0] weAddr;
    logic [DW-1:0] weData;
    int            compared = 0;
    int            mismatched = 0;
    int            cycle = 0;
    logic          rstnAtEdge = 1'b0;

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            bus.mem_ctrl[4*i +: 4] = coreCtrl[i];
            bus.daddr[AW*i +: AW]  = coreAddr[i];
            bus.dwdata[DW*i +: DW] = coreData[i];
        end
    end

    function automatic logic [DW-1:0] initVal(input int a);
        return (a == 'h10) ? 8'hA5 : DW'((a * 29 + 'h5B) & 'hFF);
    endfunction

    always @(posedge clk) begin
        cycle++;
        rstnAtEdge = rstn;
    end

    // RAM with one-cycle read latency; a write and its address are taken on the same edge.
    initial begin
        for (int a = 0; a < 256; a++) ramMem[a] = initVal(a);
        bus.ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_we) ramMem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= ramMem[bus.ram_addr];
        end
    end

    task automatic checkOutput(input string name, input int core,
                               input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s core=%0d: got 0x%0h, required 0x%0h", name, core, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int core, input int actual,
                              input int lo, input int hi);
        compared++;
        if (actual < lo || actual > hi) begin
            mismatched++;
            $display("[TB] FAIL %s core=%0d: got %0d, required %0d..%0d", name, core, actual, lo, hi);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic isWrite,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        txn_t e;
        e.isWrite    = isWrite;
        e.addr       = addr;
        e.data       = data;
        e.issueCycle = cycle;
        expQ[i].push_back(e);
        issueCycle[i] = cycle;
        coreCtrl[i]   = isWrite ? MEM_WRITE : MEM_READ;
        coreAddr[i]   = addr;
        coreData[i]   = data;
    endtask

    task automatic waitAck(input int i, input bit hold);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.dacq[i]) seen = 1'b1;
        end
        checkOutput("ack_seen", i, 32'(seen), 1);
        nextCycle();
        if (hold) nextCycle();
        coreCtrl[i] = MEM_IDLE;
    endtask

    task automatic randomCore(input int i);
        for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(0, 3)) nextCycle();
            nextCycle();
            applyStimulus(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            waitAck(i, $urandom_range(0, 3) == 0);
        end
    endtask

    // Monitor: pops the expected transaction whenever a core is acknowledged.
    initial begin
        for (int a = 0; a < 256; a++) refMem[a] = initVal(a);
        for (int i = 0; i < NCORES; i++) begin
            expDdin[i] = '0;
            ackCount[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rstnAtEdge) begin
                weCount = 0;
                for (int i = 0; i < NCORES; i++) expDdin[i] = '0;
                checkOutput("reset_dacq", -1, 32'(bus.dacq), 0);
                checkOutput("reset_ram_we", -1, 32'(bus.ram_we), 0);
                for (int i = 0; i < NCORES; i++)
                    checkOutput("reset_ddin", i, 32'(bus.ddin[DW*i +: DW]), 0);
            end else begin
                if (bus.ram_we) begin
                    weCount++;
                    weTotal++;
                    weAddr = bus.ram_addr;
                    weData = bus.ram_wdata;
                end
                if (bus.dacq != '0) begin
                    checkOutput("dacq_onehot", -1, 32'($onehot(bus.dacq)), 1);
                    for (int i = 0; i < NCORES; i++) begin
                        if (bus.dacq[i]) begin
                            ackCount[i]++;
                            ackTotal++;
                            lastAckCycle[i] = cycle;
                            ackLog.push_back(i);
                            checkOutput("dacq_has_request", i, 32'(expQ[i].size() > 0), 1);
                            if (expQ[i].size() > 0) begin
                                txn_t e;
                                e = expQ[i].pop_front();
                                if (e.isWrite) begin
                                    checkOutput("write_pulses", i, weCount, 1);
                                    checkOutput("write_addr", i, 32'(weAddr), 32'(e.addr));
                                    checkOutput("write_data", i, 32'(weData), 32'(e.data));
                                    refMem[e.addr] = e.data;
                                end else begin
                                    checkOutput("read_no_write", i, weCount, 0);
                                    expDdin[i] = refMem[e.addr];
                                end
                                checkRange("latency", i, cycle - e.issueCycle,
                                           e.isWrite ? 2 : 3, LAT_BOUND);
                            end
                        end
                    end
                    weCount = 0;
                    for (int i = 0; i < NCORES; i++)
                        checkOutput("ddin", i, 32'(bus.ddin[DW*i +: DW]), 32'(expDdin[i]));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, mismatched=%0d", mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expOrder [5];
        int base;
        int baseAck;
        int baseWe;

        for (int i = 0; i < NCORES; i++) begin
            coreCtrl[i] = MEM_IDLE;
            coreAddr[i] = '0;
            coreData[i] = '0;
        end

        // Reset state
        rstn = 1'b0;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("reset_ram_addr", -1, 32'(bus.ram_addr), 0);
        checkOutput("reset_ram_wdata", -1, 32'(bus.ram_wdata), 0);
        rstn = 1'b1;
        nextCycle();

        // Single read of a known location
        applyStimulus(1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("read_ram_addr", 1, 32'(bus.ram_addr), 'h10);
        checkOutput("read_ram_we", 1, 32'(bus.ram_we), 0);
        waitAck(1, 1'b0);
        checkOutput("read_latency", 1, lastAckCycle[1] - issueCycle[1], 3);
        checkOutput("read_data_A5", 1, 32'(bus.ddin[DW*1 +: DW]), 'hA5);

        // Write then read back from another core
        nextCycle();
        applyStimulus(2, 1'b1, 8'h20, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        checkOutput("write_ram_we", 2, 32'(bus.ram_we), 1);
        checkOutput("write_ram_addr", 2, 32'(bus.ram_addr), 'h20);
        checkOutput("write_ram_wdata", 2, 32'(bus.ram_wdata), 'h3C);
        waitAck(2, 1'b0);
        checkOutput("write_latency", 2, lastAckCycle[2] - issueCycle[2], 2);
        nextCycle();
        applyStimulus(0, 1'b0, 8'h20, 8'h00);
        waitAck(0, 1'b0);
        checkOutput("readback_3C", 0, 32'(bus.ddin[DW*0 +: DW]), 'h3C);

        // Contention from a fresh pointer, with a second core-0 request after its ack
        rstn = 1'b0;
        nextCycle();
        nextCycle();
        rstn = 1'b1;
        ackLog.delete();
        fork
            begin
                applyStimulus(0, 1'b0, 8'h40, 8'h00);
                waitAck(0, 1'b0);
                nextCycle();
                applyStimulus(0, 1'b0, 8'h44, 8'h00);
                waitAck(0, 1'b0);
            end
            begin applyStimulus(1, 1'b0, 8'h41, 8'h00); waitAck(1, 1'b0); end
            begin applyStimulus(2, 1'b0, 8'h42, 8'h00); waitAck(2, 1'b0); end
            begin applyStimulus(3, 1'b0, 8'h43, 8'h00); waitAck(3, 1'b0); end
        join
        expOrder = '{0, 1, 2, 3, 0};
        checkOutput("contention_count", -1, ackLog.size(), 5);
        for (int k = 0; k < 5 && k < ackLog.size(); k++)
            checkOutput("contention_order", k, ackLog[k], expOrder[k]);

        // Request held one cycle past its acknowledge
        nextCycle();
        base = ackCount[3];
        applyStimulus(3, 1'b0, 8'h50, 8'h00);
        waitAck(3, 1'b1);
        repeat (8) nextCycle();
        checkOutput("held_single_ack", 3, ackCount[3] - base, 1);

        // Illegal command code is never granted
        baseAck = ackTotal;
        baseWe  = weTotal;
        coreCtrl[0] = 4'd7;
        coreAddr[0] = 8'h33;
        coreData[0] = 8'hEE;
        repeat (20) nextCycle();
        checkOutput("illegal_no_ack", 0, ackTotal - baseAck, 0);
        checkOutput("illegal_no_write", 0, weTotal - baseWe, 0);
        coreCtrl[0] = MEM_IDLE;

        // Reset during RWAIT with the pointer away from zero
        nextCycle();
        applyStimulus(1, 1'b0, 8'h60, 8'h00);
        waitAck(1, 1'b0);
        nextCycle();
        ackLog.delete();
        fork
            begin applyStimulus(3, 1'b0, 8'h70, 8'h00); waitAck(3, 1'b0); end
            begin nextCycle(); applyStimulus(1, 1'b0, 8'h71, 8'h00); waitAck(1, 1'b0); end
            begin
                nextCycle();
                nextCycle();
                rstn = 1'b0;
                nextCycle();
                @(negedge clk);
                checkOutput("midreset_dacq", -1, 32'(bus.dacq), 0);
                checkOutput("midreset_ddin1", 1, 32'(bus.ddin[DW*1 +: DW]), 0);
                rstn = 1'b1;
            end
        join
        checkOutput("midreset_count", -1, ackLog.size(), 2);
        if (ackLog.size() >= 2) begin
            checkOutput("midreset_order0", -1, ackLog[0], 1);
            checkOutput("midreset_order1", -1, ackLog[1], 3);
        end

        // Randomized concurrent traffic on a small address window
        fork
            randomCore(0);
            randomCore(1);
            randomCore(2);
            randomCore(3);
        join
        repeat (10) nextCycle();
        for (int i = 0; i < NCORES; i++)
            checkOutput("queue_drained", i, expQ[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
